// File: rtl/k12a_io_ports.sv
// k12a IO peripheral: GPIO output/input ports, edge-flag wake logic and a timed LCD strobe engine.
// LCD FSM states:  IDLE | no transfer, CTRL/LCD_DATA writable
//                  PULSE | lcd_en high for LCD_PULSE_CYCLES cycles
//                  HOLD  | lcd_en low for LCD_PULSE_CYCLES cycles before the next transfer
module k12a_io_ports #(
    parameter int NUM_OUT          = 3,
    parameter int NUM_IN           = 3,
    parameter int ADDR_WIDTH       = 5,
    parameter int LCD_PULSE_CYCLES = 4
) (
    input  logic                  cpu_clock,
    input  logic                  reset,
    input  logic                  io_load,
    input  logic                  io_store,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    inout  wire  [7:0]            data_bus,
    output logic [8*NUM_OUT-1:0]  gpio_out,
    input  logic [8*NUM_IN-1:0]   gpio_in,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic                  lcd_en,
    output logic [7:0]            lcd_data,
    output logic                  wake
);

    if (NUM_OUT + 4*NUM_IN + 2 > (1 << ADDR_WIDTH)) begin : g_bad_map
        $error("k12a_io_ports: register map does not fit in io_addr");
    end

    localparam int A_IN   = NUM_OUT;
    localparam int A_FLAG = NUM_OUT + NUM_IN;
    localparam int A_RM   = NUM_OUT + 2*NUM_IN;
    localparam int A_FM   = NUM_OUT + 3*NUM_IN;
    localparam int A_CTRL = NUM_OUT + 4*NUM_IN;
    localparam int A_LCD  = A_CTRL + 1;
    localparam logic [7:0] CNT_LOAD = 8'(LCD_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_lcd_en;
    logic                  r_lcd_rs;
    logic [7:0]            r_lcd_data;
    logic [8*NUM_OUT-1:0]  r_out;
    logic [8*NUM_IN-1:0]   r_s1, r_s2, r_s3;
    logic [8*NUM_IN-1:0]   r_flag, r_rmask, r_fmask;

    logic [31:0]           w_addr;
    logic                  w_busy;
    logic                  w_rd_hit;
    logic [7:0]            w_rd_data;
    logic [8*NUM_IN-1:0]   w_clr;
    logic [8*NUM_IN-1:0]   w_flag_next;
    logic                  w_wr_ctrl, w_wr_lcd;

    assign w_addr    = 32'(io_addr);
    assign w_busy    = (r_state != ST_IDLE);
    assign w_wr_ctrl = io_store && (w_addr == A_CTRL) && !w_busy;
    assign w_wr_lcd  = io_store && (w_addr == A_LCD) && !w_busy;

    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_data = 8'h00;
        w_clr     = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (w_addr == k) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_out[8*k +: 8];
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (w_addr == A_IN + k) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_s2[8*k +: 8];
            end
            if (w_addr == A_FLAG + k) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_flag[8*k +: 8];
                if (io_store) w_clr[8*k +: 8] = data_bus;
            end
            if (w_addr == A_RM + k) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_rmask[8*k +: 8];
            end
            if (w_addr == A_FM + k) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_fmask[8*k +: 8];
            end
        end
        if (w_addr == A_CTRL) begin
            w_rd_hit  = 1'b1;
            w_rd_data = {w_busy, 6'b0, r_lcd_rs};
        end
        if (w_addr == A_LCD) begin
            w_rd_hit  = 1'b1;
            w_rd_data = r_lcd_data;
        end
    end

    // A simultaneous store owns the bus, so the block stays off it.
    assign data_bus = (io_load && !io_store && w_rd_hit) ? w_rd_data : 8'hzz;

    // Set beats clear when both land on the same bit in the same cycle.
    assign w_flag_next = (r_flag & ~w_clr) | (r_s2 & ~r_s3 & r_rmask) | (~r_s2 & r_s3 & r_fmask);

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            r_out   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_flag  <= '0;
            r_rmask <= '0;
            r_fmask <= '0;
        end else begin
            r_s1   <= gpio_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_flag <= w_flag_next;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (io_store && w_addr == k) r_out[8*k +: 8] <= data_bus;
            end
            for (int k = 0; k < NUM_IN; k++) begin
                if (io_store && w_addr == A_RM + k) r_rmask[8*k +: 8] <= data_bus;
                if (io_store && w_addr == A_FM + k) r_fmask[8*k +: 8] <= data_bus;
            end
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'h00;
            r_lcd_en   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
        end else begin
            if (w_wr_ctrl)  r_lcd_rs   <= data_bus[0];
            if (w_wr_lcd)   r_lcd_data <= data_bus;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_ctrl && data_bus[7]) begin
                        r_state  <= ST_PULSE;
                        r_cnt    <= CNT_LOAD;
                        r_lcd_en <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == 8'h00) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= CNT_LOAD;
                        r_lcd_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'h01;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 8'h00) r_state <= ST_IDLE;
                    else                r_cnt   <= r_cnt - 8'h01;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_lcd_en <= 1'b0;
                end
            endcase
        end
    end

    assign gpio_out = r_out;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = r_lcd_en;
    assign lcd_data = r_lcd_data;
    assign wake     = |r_flag;

endmodule

// File: tb/tb_k12a_io_ports.sv
// Bench for k12a_io_ports: directed scenarios then random bus/input traffic, checked
// cycle by cycle against a register-map level reference model.
module tb_k12a_io_ports;

    localparam int O = 3;
    localparam int I = 3;
    localparam int P = 4;
    localparam int A_CTRL = O + 4*I;
    localparam int A_LCD  = A_CTRL + 1;

    logic        cpu_clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_load = 1'b0;
    logic        io_store = 1'b0;
    logic [4:0]  io_addr = 5'd0;
    wire  [7:0]  data_bus;
    logic [23:0] gpio_out;
    logic [23:0] gpio_in = 24'h0;
    logic        lcd_rs, lcd_rw, lcd_en, wake;
    logic [7:0]  lcd_data;
    logic [7:0]  tb_drv = 8'h00;
    logic        tb_drv_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    assign data_bus = tb_drv_en ? tb_drv : 8'hzz;

    always #5 cpu_clock = ~cpu_clock;

    k12a_io_ports #(.NUM_OUT(O), .NUM_IN(I), .ADDR_WIDTH(5), .LCD_PULSE_CYCLES(P)) u_dut (
        .cpu_clock(cpu_clock), .reset(reset), .io_load(io_load), .io_store(io_store),
        .io_addr(io_addr), .data_bus(data_bus), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data), .wake(wake)
    );

    // Reference model state
    logic [7:0]  m_out[O];
    logic [7:0]  m_flag[I];
    logic [7:0]  m_rm[I];
    logic [7:0]  m_fm[I];
    logic [23:0] m_hist[3];   // gpio_in sampled at the last three edges, newest first
    int          m_left;      // busy cycles remaining in the current LCD transfer
    logic        m_rs;
    logic [7:0]  m_ld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input int a);
        logic [23:0] s2;
        s2 = m_hist[1];
        if (a < O)                   return m_out[a];
        if (a >= O && a < O+I)       return s2[8*(a-O) +: 8];
        if (a >= O+I && a < O+2*I)   return m_flag[a-O-I];
        if (a >= O+2*I && a < O+3*I) return m_rm[a-O-2*I];
        if (a >= O+3*I && a < O+4*I) return m_fm[a-O-3*I];
        if (a == A_CTRL)             return {m_left > 0, 6'b0, m_rs};
        if (a == A_LCD)              return m_ld;
        return 8'hzz;
    endfunction

    task automatic model_edge(input bit rst, input bit st, input int a, input logic [7:0] wd,
                              input logic [23:0] g);
        logic [23:0] s2, s3;
        logic [7:0]  clr, set;
        bit          start;
        if (rst) begin
            for (int k = 0; k < O; k++) m_out[k] = 8'h00;
            for (int k = 0; k < I; k++) begin
                m_flag[k] = 8'h00; m_rm[k] = 8'h00; m_fm[k] = 8'h00;
            end
            for (int k = 0; k < 3; k++) m_hist[k] = 24'h0;
            m_left = 0; m_rs = 1'b0; m_ld = 8'h00;
            return;
        end
        s2 = m_hist[1];
        s3 = m_hist[2];
        for (int k = 0; k < I; k++) begin
            set = (s2[8*k +: 8] & ~s3[8*k +: 8] & m_rm[k]) | (~s2[8*k +: 8] & s3[8*k +: 8] & m_fm[k]);
            clr = (st && a == O+I+k) ? wd : 8'h00;
            m_flag[k] = (m_flag[k] & ~clr) | set;
        end
        start = 1'b0;
        if (st) begin
            if (a < O) m_out[a] = wd;
            else if (a >= O+2*I && a < O+3*I) m_rm[a-O-2*I] = wd;
            else if (a >= O+3*I && a < O+4*I) m_fm[a-O-3*I] = wd;
            else if (a == A_CTRL && m_left == 0) begin
                m_rs  = wd[0];
                start = wd[7];
            end else if (a == A_LCD && m_left == 0) m_ld = wd;
        end
        if (start)           m_left = 2*P;
        else if (m_left > 0) m_left--;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = g;
    endtask

    // One bus cycle: apply inputs, check any read, clock, then check the outputs.
    task automatic do_cycle(input bit rst, input bit ld, input bit st, input int a,
                            input logic [7:0] wd, input logic [23:0] g);
        logic [7:0] wk;
        reset = rst; io_load = ld; io_store = st; io_addr = 5'(a);
        tb_drv = wd; tb_drv_en = st; gpio_in = g;
        #2;
        if (ld && st)  chk("bus_shared", {24'h0, data_bus}, {24'h0, wd});
        else if (ld)   chk($sformatf("read_a%0d", a), {24'h0, data_bus}, {24'h0, model_read(a)});
        @(posedge cpu_clock);
        model_edge(rst, st, a, wd, g);
        #1;
        wk = m_flag[0] | m_flag[1] | m_flag[2];
        chk("gpio_out", {8'h0, gpio_out}, {8'h0, m_out[2], m_out[1], m_out[0]});
        chk("wake", {31'h0, wake}, {31'h0, wk != 8'h00});
        chk("lcd_en", {31'h0, lcd_en}, {31'h0, m_left > P});
        chk("lcd_rs", {31'h0, lcd_rs}, {31'h0, m_rs});
        chk("lcd_data", {24'h0, lcd_data}, {24'h0, m_ld});
        chk("lcd_rw", {31'h0, lcd_rw}, 32'h0);
    endtask

    task automatic idle(input int n, input int a, input logic [23:0] g);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, 1'b0, a, 8'h00, g);
    endtask

    initial begin
        logic [23:0] g;
        int          hi_cnt;
        g = 24'h0;
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, 0, 8'h00, g);

        // Output port and unmapped read
        do_cycle(1'b0, 1'b0, 1'b1, 1, 8'hA5, g);
        chk("out1_a5", {24'h0, gpio_out[15:8]}, 32'hA5);
        idle(1, 1, g);
        idle(1, 31, g);

        // Input synchroniser and ignored store to an input port
        g = 24'h00003C;
        idle(4, 3, g);
        do_cycle(1'b0, 1'b0, 1'b1, 3, 8'hFF, g);
        idle(1, 3, g);

        // Rising-edge flag, clear, and clear coinciding with a new set
        do_cycle(1'b0, 1'b0, 1'b1, 9, 8'h01, g);
        g[0] = 1'b1;
        idle(4, 6, g);
        chk("wake_rise", {31'h0, wake}, 32'h1);
        do_cycle(1'b0, 1'b1, 1'b1, 6, 8'h01, g);
        idle(1, 6, g);
        g[0] = 1'b0; idle(3, 6, g);
        g[0] = 1'b1;
        do_cycle(1'b0, 1'b1, 1'b0, 6, 8'h00, g);
        do_cycle(1'b0, 1'b1, 1'b0, 6, 8'h00, g);
        do_cycle(1'b0, 1'b0, 1'b1, 6, 8'h01, g);
        idle(2, 6, g);

        // Falling-edge flag on bit 7, rising edge on bit 7 ignored
        do_cycle(1'b0, 1'b0, 1'b1, 6, 8'hFF, g);
        do_cycle(1'b0, 1'b0, 1'b1, 12, 8'h80, g);
        do_cycle(1'b0, 1'b0, 1'b1, 9, 8'h00, g);
        g[7] = 1'b1; idle(4, 6, g);
        do_cycle(1'b0, 1'b0, 1'b1, 6, 8'hFF, g);
        g[7] = 1'b0; idle(4, 6, g);
        g[7] = 1'b1; idle(4, 6, g);

        // LCD transfer with writes attempted while busy
        do_cycle(1'b0, 1'b0, 1'b1, A_LCD, 8'h42, g);
        do_cycle(1'b0, 1'b0, 1'b1, A_CTRL, 8'h81, g);
        hi_cnt = lcd_en ? 1 : 0;
        do_cycle(1'b0, 1'b0, 1'b1, A_LCD, 8'h00, g);
        hi_cnt += lcd_en ? 1 : 0;
        do_cycle(1'b0, 1'b0, 1'b1, A_CTRL, 8'h80, g);
        hi_cnt += lcd_en ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, A_CTRL, 8'h00, g);
            hi_cnt += lcd_en ? 1 : 0;
        end
        chk("lcd_en_width", 32'(hi_cnt), 32'(P));
        do_cycle(1'b0, 1'b0, 1'b1, A_CTRL, 8'h80, g);   // final HOLD cycle: ignored
        idle(3, A_CTRL, g);

        // Reset during PULSE, then a shared load/store on OUT0
        do_cycle(1'b0, 1'b0, 1'b1, 0, 8'h77, g);
        do_cycle(1'b0, 1'b0, 1'b1, A_CTRL, 8'h80, g);
        do_cycle(1'b0, 1'b0, 1'b0, 0, 8'h00, g);
        do_cycle(1'b1, 1'b0, 1'b0, 0, 8'h00, g);
        chk("rst_lcd_en", {31'h0, lcd_en}, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b1, 0, 8'h11, g);
        chk("out0_11", {24'h0, gpio_out[7:0]}, 32'h11);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int a;
            bit ld, st, rst;
            a   = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, A_LCD)) : int'($urandom_range(0, 31));
            ld  = ($urandom_range(0, 1) == 1);
            st  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) g = g ^ (24'($urandom) & 24'($urandom) & 24'($urandom));
            do_cycle(rst, ld, st, a, 8'($urandom), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
